// File: rtl/video_pkg.sv
// video_pkg: shared FSM encodings, 640x480 timing constants and width helper
package video_pkg;

    typedef enum logic [1:0] {V_IDLE, V_ACTIVE, V_DONE} v_state_t;
    typedef enum logic [1:0] {H_IDLE, H_DRAW, H_DONE} h_state_t;

    localparam int H_VISIBLE = 640;
    localparam int H_FRONT   = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BACK    = 48;
    localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_VISIBLE = 480;
    localparam int V_FRONT   = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BACK    = 33;
    localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    // index width for a count of n items, never zero
    function automatic int cw(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sprite_bitmap_rom.sv
// sprite_bitmap_rom: combinational 1-bit sprite bitmap, MSB is the leftmost pixel
module sprite_bitmap_rom
    import video_pkg::*;
#(
    parameter int SPR_W = 8,
    parameter int SPR_H = 8
) (
    input  logic [cw(SPR_H)-1:0] i_row,
    output logic [SPR_W-1:0]     o_bits
);

    // row lookup; rows not listed are blank
    always_comb begin
        case (int'(i_row))
            0:       o_bits = SPR_W'(8'b1000_0001);
            1:       o_bits = SPR_W'(8'b0100_0010);
            2:       o_bits = SPR_W'(8'b0010_0100);
            3:       o_bits = SPR_W'(8'b0001_1000);
            4:       o_bits = SPR_W'(8'b0001_1000);
            5:       o_bits = SPR_W'(8'b0010_0100);
            6:       o_bits = SPR_W'(8'b0100_0010);
            7:       o_bits = SPR_W'(8'b1111_1111);
            default: o_bits = '0;
        endcase
    end

endmodule

// File: rtl/bitmapped_sprite_renderer.sv
// bitmapped_sprite_renderer: scaled 1-bit sprite composited over a VGA raster, 2-cycle latency
module bitmapped_sprite_renderer
    import video_pkg::*;
#(
    parameter int                     COORD_W     = 10,
    parameter int                     SPR_W       = 8,
    parameter int                     SPR_H       = 8,
    parameter int                     SCALE_LOG2  = 2,
    parameter int                     COLOR_W     = 8,
    parameter logic [3*COLOR_W-1:0]   FG_RGB      = 24'hFFFFFF,
    parameter bit                     TRANSPARENT = 1'b1
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [COORD_W-1:0] i_hpos,
    input  logic [COORD_W-1:0] i_vpos,
    input  logic               i_visible,
    input  logic               i_hsync,
    input  logic               i_vsync,
    input  logic [COORD_W-1:0] i_sprite_x,
    input  logic [COORD_W-1:0] i_sprite_y,
    input  logic               i_sprite_en,
    input  logic [COLOR_W-1:0] i_bg_r,
    input  logic [COLOR_W-1:0] i_bg_g,
    input  logic [COLOR_W-1:0] i_bg_b,
    output logic [COLOR_W-1:0] o_r,
    output logic [COLOR_W-1:0] o_g,
    output logic [COLOR_W-1:0] o_b,
    output logic               o_hsync,
    output logic               o_vsync,
    output logic               o_busy
);

    localparam int RW = cw(SPR_H);
    localparam int CW = cw(SPR_W);
    localparam int SW = SCALE_LOG2 > 0 ? SCALE_LOG2 : 1;
    localparam logic [SW-1:0] SUB_MAX = SW'((1 << SCALE_LOG2) - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(SPR_H - 1);
    localparam logic [CW-1:0] COL_MAX = CW'(SPR_W - 1);

    v_state_t             r_v, w_v_n, w_v_base;
    h_state_t             r_h, w_h_n;
    logic [COORD_W-1:0]   r_x, r_y, w_x, w_y;
    logic                 r_en, w_en;
    logic [RW-1:0]        r_row, w_row_n;
    logic [SW-1:0]        r_vsub, w_vsub_n, r_hsub, w_hsub, w_hsub_n;
    logic [CW-1:0]        r_col, w_col, w_col_n;
    logic                 w_latch, w_line, w_vwrap, w_hwrap, w_vact, w_hstart, w_hdraw;
    logic [SPR_W-1:0]     w_bits;
    logic [SPR_W-1:0]     r_s1_bits;
    logic [CW-1:0]        r_s1_col;
    logic                 r_s1_draw, r_s1_vis, r_s1_hs, r_s1_vs;
    logic [3*COLOR_W-1:0] r_s1_bg, w_rgb, r_rgb;
    logic                 r_hs, r_vs, w_bit;

    // the frame latch sees the live inputs so a sprite at y=0 or x=0 starts on the latch cycle
    assign w_latch  = i_hpos == '0 && i_vpos == '0;
    assign w_line   = i_hpos == '0;
    assign w_x      = w_latch ? i_sprite_x : r_x;
    assign w_y      = w_latch ? i_sprite_y : r_y;
    assign w_en     = w_latch ? i_sprite_en : r_en;
    assign w_v_base = w_latch ? V_IDLE : r_v;
    assign w_vwrap  = r_vsub == SUB_MAX;

    // vertical next state: steps once per line at hpos 0
    always_comb begin
        w_v_n    = w_v_base;
        w_row_n  = w_latch ? '0 : r_row;
        w_vsub_n = w_latch ? '0 : r_vsub;
        if (w_line && w_v_base == V_IDLE && i_vpos == w_y && w_en) begin
            w_v_n    = V_ACTIVE;
            w_row_n  = '0;
            w_vsub_n = '0;
        end else if (w_line && w_v_base == V_ACTIVE) begin
            w_vsub_n = w_vwrap ? '0 : r_vsub + SW'(1);
            w_row_n  = w_vwrap ? (r_row == ROW_MAX ? '0 : r_row + RW'(1)) : r_row;
            w_v_n    = (w_vwrap && r_row == ROW_MAX) ? V_DONE : V_ACTIVE;
        end
    end

    // the current pixel belongs to the sprite when it starts here or a run is already in progress
    assign w_vact   = w_v_n == V_ACTIVE;
    assign w_hstart = w_vact && i_hpos == w_x && (r_h == H_IDLE || w_line);
    assign w_hdraw  = w_hstart || (w_vact && r_h == H_DRAW && !w_line);
    assign w_col    = w_hstart ? '0 : r_col;
    assign w_hsub   = w_hstart ? '0 : r_hsub;
    assign w_hwrap  = w_hsub == SUB_MAX;

    // horizontal next state: one sub-pixel per cycle, cleared at the start of every line
    always_comb begin
        w_h_n    = w_line ? H_IDLE : r_h;
        w_col_n  = w_col;
        w_hsub_n = w_hsub;
        if (w_hdraw) begin
            w_hsub_n = w_hwrap ? '0 : w_hsub + SW'(1);
            w_col_n  = w_hwrap ? (w_col == COL_MAX ? '0 : w_col + CW'(1)) : w_col;
            w_h_n    = (w_hwrap && w_col == COL_MAX) ? H_DONE : H_DRAW;
        end
    end

    // FSM state, counters and per-frame sprite position
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_v    <= V_IDLE;
            r_h    <= H_IDLE;
            r_x    <= '0;
            r_y    <= '0;
            r_en   <= 1'b0;
            r_row  <= '0;
            r_vsub <= '0;
            r_col  <= '0;
            r_hsub <= '0;
        end else begin
            r_v    <= w_v_n;
            r_h    <= w_h_n;
            r_x    <= w_x;
            r_y    <= w_y;
            r_en   <= w_en;
            r_row  <= w_row_n;
            r_vsub <= w_vsub_n;
            r_col  <= w_col_n;
            r_hsub <= w_hsub_n;
        end
    end

    sprite_bitmap_rom #(.SPR_W(SPR_W), .SPR_H(SPR_H)) u_rom (
        .i_row  (w_row_n),
        .o_bits (w_bits)
    );

    // stage 2 colour select: foreground on set bits, background or black elsewhere
    always_comb begin
        w_bit = r_s1_bits[COL_MAX - r_s1_col];
        w_rgb = !r_s1_vis ? '0 : (r_s1_draw && w_bit) ? FG_RGB : (r_s1_draw && !TRANSPARENT) ? '0 : r_s1_bg;
    end

    // two-stage pixel pipeline; syncs travel alongside so they stay aligned with colour
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_s1_bits <= '0;
            r_s1_col  <= '0;
            r_s1_draw <= 1'b0;
            r_s1_vis  <= 1'b0;
            r_s1_bg   <= '0;
            r_s1_hs   <= 1'b0;
            r_s1_vs   <= 1'b0;
            r_rgb     <= '0;
            r_hs      <= 1'b0;
            r_vs      <= 1'b0;
        end else begin
            r_s1_bits <= w_bits;
            r_s1_col  <= w_col;
            r_s1_draw <= w_hdraw;
            r_s1_vis  <= i_visible;
            r_s1_bg   <= {i_bg_r, i_bg_g, i_bg_b};
            r_s1_hs   <= i_hsync;
            r_s1_vs   <= i_vsync;
            r_rgb     <= w_rgb;
            r_hs      <= r_s1_hs;
            r_vs      <= r_s1_vs;
        end
    end

    assign o_r     = r_rgb[3*COLOR_W-1:2*COLOR_W];
    assign o_g     = r_rgb[2*COLOR_W-1:COLOR_W];
    assign o_b     = r_rgb[COLOR_W-1:0];
    assign o_hsync = r_hs;
    assign o_vsync = r_vs;
    assign o_busy  = r_v == V_ACTIVE;

endmodule

// File: tb/tb_bitmapped_sprite_renderer.sv
// tb_bitmapped_sprite_renderer: directed raster checks for a transparent and an opaque renderer
module tb_bitmapped_sprite_renderer;

    localparam logic [23:0] FG = 24'hFFFFFF;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [9:0]  hpos = '0, vpos = '0, sx = '0, sy = '0;
    logic        vis = 1'b0, hs = 1'b0, vs = 1'b0, en = 1'b0;
    logic [23:0] bg = 24'h123456;
    logic [7:0]  r1, g1, b1, r0, g0, b0;
    logic        hs1, vs1, hs0, vs0, busy1, busy0;
    logic [25:0] cur1 = '0, prev1 = '0, cur0 = '0, prev0 = '0;
    int          cur_h = 0, cur_v = 0, prev_h = 0, prev_v = 0;
    int          n_assert = 0, n_fail = 0;
    logic [7:0]  rom [8];

    always #5 clk = ~clk;

    bitmapped_sprite_renderer u_dut (
        .i_clk(clk), .i_rst(rst), .i_hpos(hpos), .i_vpos(vpos), .i_visible(vis),
        .i_hsync(hs), .i_vsync(vs), .i_sprite_x(sx), .i_sprite_y(sy), .i_sprite_en(en),
        .i_bg_r(bg[23:16]), .i_bg_g(bg[15:8]), .i_bg_b(bg[7:0]),
        .o_r(r1), .o_g(g1), .o_b(b1), .o_hsync(hs1), .o_vsync(vs1), .o_busy(busy1)
    );

    bitmapped_sprite_renderer #(.TRANSPARENT(1'b0)) u_opaque (
        .i_clk(clk), .i_rst(rst), .i_hpos(hpos), .i_vpos(vpos), .i_visible(vis),
        .i_hsync(hs), .i_vsync(vs), .i_sprite_x(sx), .i_sprite_y(sy), .i_sprite_en(en),
        .i_bg_r(bg[23:16]), .i_bg_g(bg[15:8]), .i_bg_b(bg[7:0]),
        .o_r(r0), .o_g(g0), .o_b(b0), .o_hsync(hs0), .o_vsync(vs0), .o_busy(busy0)
    );

    // drive one pixel at a falling edge; the output seen one edge later belongs to the previous pixel
    task automatic px(input int h, input int v, input bit fg, input bit inbox);
        bit vis_l;
        vis_l = h < 640 && v < 480;
        hpos = 10'(h);
        vpos = 10'(v);
        vis = vis_l;
        hs = 1'($urandom_range(1));
        vs = 1'($urandom_range(1));
        prev1 = cur1;
        prev0 = cur0;
        prev_h = cur_h;
        prev_v = cur_v;
        cur_h = h;
        cur_v = v;
        cur1 = {!vis_l ? 24'h0 : fg ? FG : bg, hs, vs};
        cur0 = {!vis_l ? 24'h0 : fg ? FG : inbox ? 24'h0 : bg, hs, vs};
        @(negedge clk);
        n_assert++;
        assert ({r1, g1, b1, hs1, vs1} === prev1)
        else begin
            n_fail++;
            $error("FAIL transparent h=%0d v=%0d {rgb,hs,vs} observed=%h expected=%h", prev_h, prev_v, {r1, g1, b1, hs1, vs1}, prev1);
        end
        n_assert++;
        assert ({r0, g0, b0, hs0, vs0} === prev0)
        else begin
            n_fail++;
            $error("FAIL opaque h=%0d v=%0d {rgb,hs,vs} observed=%h expected=%h", prev_h, prev_v, {r0, g0, b0, hs0, vs0}, prev0);
        end
    endtask

    // one line: hpos 0, busy check, then a contiguous window; box at bx with the given source row bits
    task automatic line(input int v, input int lo, input int hi, input int bx, input bit inb,
                        input logic [7:0] bits, input bit bsy);
        bit in_l;
        px(0, v, 1'b0, 1'b0);
        n_assert++;
        assert (busy1 === bsy && busy0 === bsy)
        else begin
            n_fail++;
            $error("FAIL busy v=%0d observed=%b/%b expected=%b", v, busy1, busy0, bsy);
        end
        for (int h = lo; h <= hi; h++) begin
            in_l = inb && h >= bx && h < bx + 32;
            px(h, v, in_l && bits[7 - (h - bx) / 4], in_l);
        end
    endtask

    task automatic chk_reset(input string tag);
        n_assert++;
        assert ({r1, g1, b1, hs1, vs1, busy1, r0, g0, b0, hs0, vs0, busy0} === 54'h0)
        else begin
            n_fail++;
            $error("FAIL %s outputs observed=%h expected=0", tag, {r1, g1, b1, hs1, vs1, busy1, r0, g0, b0, hs0, vs0, busy0});
        end
    endtask

    initial begin
        rom = '{8'b1000_0001, 8'b0100_0010, 8'b0010_0100, 8'b0001_1000,
                8'b0001_1000, 8'b0010_0100, 8'b0100_0010, 8'b1111_1111};
        #2 rst = 1'b1;
        #1 chk_reset("reset_state");
        @(negedge clk);
        rst = 1'b0;

        // frame 1: x=100 y=50, x moves to 300 mid-frame but this frame stays at 100
        sx = 10'd100; sy = 10'd50; en = 1'b1;
        line(0, 1, 2, 100, 1'b0, 8'h00, 1'b0);
        line(49, 96, 135, 100, 1'b0, 8'h00, 1'b0);
        for (int v = 50; v < 82; v++) begin
            if (v == 60) sx = 10'd300;
            line(v, 96, 335, 100, 1'b1, rom[(v - 50) / 4], 1'b1);
        end
        line(82, 96, 135, 100, 1'b0, 8'h00, 1'b0);

        // frame 2: new position takes effect
        line(0, 1, 2, 300, 1'b0, 8'h00, 1'b0);
        for (int v = 50; v < 82; v++) line(v, 96, 335, 300, 1'b1, rom[(v - 50) / 4], 1'b1);
        line(82, 290, 335, 300, 1'b0, 8'h00, 1'b0);

        // frame 3: bottom-right clipping
        sx = 10'd636; sy = 10'd478;
        line(0, 1, 2, 636, 1'b0, 8'h00, 1'b0);
        line(477, 630, 660, 636, 1'b0, 8'h00, 1'b0);
        for (int v = 478; v < 510; v++) line(v, 630, 660, 636, 1'b1, rom[(v - 478) / 4], 1'b1);
        line(510, 630, 660, 636, 1'b0, 8'h00, 1'b0);

        // frame 4: x past line end, nothing drawn but busy spans 32 lines
        sx = 10'd900; sy = 10'd10;
        line(0, 1, 2, 900, 1'b0, 8'h00, 1'b0);
        line(9, 630, 645, 900, 1'b0, 8'h00, 1'b0);
        for (int v = 10; v < 42; v++) line(v, 630, 645, 900, 1'b0, 8'h00, 1'b1);
        line(42, 630, 645, 900, 1'b0, 8'h00, 1'b0);

        // frame 5: async reset in the middle of line 55
        sx = 10'd100; sy = 10'd50;
        line(0, 1, 2, 100, 1'b0, 8'h00, 1'b0);
        for (int v = 50; v < 55; v++) line(v, 96, 135, 100, 1'b1, rom[(v - 50) / 4], 1'b1);
        line(55, 96, 104, 100, 1'b1, rom[1], 1'b1);
        #2 rst = 1'b1;
        #1 chk_reset("async_reset");
        @(negedge clk);
        rst = 1'b0;
        cur1 = '0;
        cur0 = '0;
        for (int v = 55; v < 61; v++) line(v, 96, 135, 100, 1'b0, 8'h00, 1'b0);
        line(0, 1, 2, 100, 1'b0, 8'h00, 1'b0);
        for (int v = 50; v < 54; v++) line(v, 96, 135, 100, 1'b1, rom[0], 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
